// File: rtl/loop_nest_sequencer.sv
// Two-level loop sequencer: emits one valid/ready beat per (i,j) with per-outer and run-persistent counters.
// Latency: first beat one cycle after start is accepted; one beat per cycle at full ready; fields held while stalled.
module loop_nest_sequencer #(
  parameter int OUTER_W = 8,
  parameter int INNER_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [OUTER_W-1:0] outer_cfg,
  input  logic [INNER_W-1:0] inner_cfg,
  input  logic               clr_static,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUTER_W-1:0] out_i,
  output logic [INNER_W-1:0] out_j,
  output logic [INNER_W-1:0] auto_cnt,
  output logic [CNT_W-1:0]   static_cnt,
  output logic               last,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [OUTER_W-1:0] outer_lat;
  logic [INNER_W-1:0] inner_lat;
  logic               xfer;
  logic               cfg_ok;
  logic               j_end;
  logic [OUTER_W-1:0] i_next;
  logic [INNER_W-1:0] j_next;
  logic               last_next;

  assign xfer   = (state == RUN) && out_ready;
  assign cfg_ok = (outer_cfg != '0) && (inner_cfg != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = cfg_ok ? RUN : DONE;
      RUN:     if (xfer && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == RUN);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Next loop position; only consumed on a non-last transfer.
  always_comb begin
    j_end     = (out_j == inner_lat - INNER_W'(1));
    i_next    = j_end ? out_i + OUTER_W'(1) : out_i;
    j_next    = j_end ? '0 : out_j + INNER_W'(1);
    last_next = (i_next == outer_lat - OUTER_W'(1)) && (j_next == inner_lat - INNER_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outer_lat  <= '0;
      inner_lat  <= '0;
      out_i      <= '0;
      out_j      <= '0;
      auto_cnt   <= '0;
      static_cnt <= '0;
      last       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            outer_lat <= outer_cfg;
            inner_lat <= inner_cfg;
            if (cfg_ok) begin
              out_i      <= '0;
              out_j      <= '0;
              auto_cnt   <= INNER_W'(1);
              // Clear takes effect before the first beat's increment.
              static_cnt <= (clr_static ? '0 : static_cnt) + CNT_W'(1);
              last       <= (outer_cfg == OUTER_W'(1)) && (inner_cfg == INNER_W'(1));
            end else if (clr_static) begin
              static_cnt <= '0;
            end
          end else if (clr_static) begin
            static_cnt <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (last) begin
              last <= 1'b0;
            end else begin
              out_i      <= i_next;
              out_j      <= j_next;
              auto_cnt   <= j_next + INNER_W'(1);
              static_cnt <= static_cnt + CNT_W'(1);
              last       <= last_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// Directed bench for loop_nest_sequencer: 3x3 runs, stalls, clears, zero cfg, mid-run reset, 4-bit counter wrap.
module tb_loop_nest_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, start4, clr_static, out_ready;
  logic [7:0]  outer_cfg, inner_cfg;

  logic        out_valid, last, busy, done;
  logic [7:0]  out_i, out_j, auto_cnt;
  logic [15:0] static_cnt;

  logic        valid4, last4, busy4, done4;
  logic [7:0]  i4, j4, auto4;
  logic [3:0]  static4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  loop_nest_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .outer_cfg(outer_cfg), .inner_cfg(inner_cfg),
    .clr_static(clr_static), .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i),
    .out_j(out_j), .auto_cnt(auto_cnt), .static_cnt(static_cnt), .last(last), .busy(busy),
    .done(done)
  );

  loop_nest_sequencer #(.OUTER_W(8), .INNER_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .outer_cfg(outer_cfg), .inner_cfg(inner_cfg),
    .clr_static(clr_static), .out_valid(valid4), .out_ready(out_ready), .out_i(i4),
    .out_j(j4), .auto_cnt(auto4), .static_cnt(static4), .last(last4), .busy(busy4),
    .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 3x3 run; stall applies ready pattern 1,0,0; stop_at < 9 leaves the run in progress.
  task automatic run33(input int first_static, input bit stall, input bit with_clr, input int stop_at);
    int k = 0;
    int cyc = 0;
    bit prev_stall = 0;
    logic [7:0]  hi, hj, ha;
    logic [15:0] hs;
    logic        hl;
    outer_cfg  = 8'd3;
    inner_cfg  = 8'd3;
    start      = 1'b1;
    clr_static = with_clr;
    tick();
    start      = 1'b0;
    clr_static = 1'b0;
    while (k < stop_at && cyc < 100) begin
      chk("run_valid", out_valid, 1);
      if (prev_stall) begin
        chk("stall_i", out_i, hi);
        chk("stall_j", out_j, hj);
        chk("stall_auto", auto_cnt, ha);
        chk("stall_static", static_cnt, hs);
        chk("stall_last", last, hl);
      end
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (out_ready) begin
        chk("beat_i", out_i, k / 3);
        chk("beat_j", out_j, k % 3);
        chk("beat_auto", auto_cnt, k % 3 + 1);
        chk("beat_static", static_cnt, first_static + k);
        chk("beat_last", last, k == 8);
        k++;
        prev_stall = 0;
      end else begin
        hi = out_i; hj = out_j; ha = auto_cnt; hs = static_cnt; hl = last;
        prev_stall = 1;
      end
      tick();
      cyc++;
    end
    chk("beat_count", k, stop_at);
    if (stop_at == 9) begin
      if (!stall) chk("beat_cycles", cyc, 9);
      chk("done_pulse", done, 1);
      chk("done_valid", out_valid, 0);
      chk("done_busy", busy, 1);
      chk("done_static_hold", static_cnt, first_static + 8);
      tick();
      chk("done_clear", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
    end
  endtask

  initial begin
    int k;
    int cyc;
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; clr_static = 1'b0; out_ready = 1'b0;
    outer_cfg = '0; inner_cfg = '0;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", last, 0);
    chk("rst_static", static_cnt, 0);
    chk("rst_auto", auto_cnt, 0);
    rst_n = 1'b1;
    tick();

    run33(1, 0, 0, 9);
    run33(10, 0, 0, 9);
    clr_static = 1'b1;
    tick();
    clr_static = 1'b0;
    chk("clr_static", static_cnt, 0);
    run33(1, 0, 0, 9);
    run33(1, 0, 1, 9);
    run33(10, 1, 0, 9);

    // Zero counts: no beats, straight to the done pulse.
    outer_cfg = 8'd0; inner_cfg = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zo_valid", out_valid, 0);
    chk("zo_done", done, 1);
    tick();
    chk("zo_done_end", done, 0);
    chk("zo_busy", busy, 0);
    outer_cfg = 8'd3; inner_cfg = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zi_valid", out_valid, 0);
    chk("zi_done", done, 1);
    chk("zi_static", static_cnt, 18);
    tick();
    chk("zi_done_end", done, 0);

    // Reset in the middle of a run.
    run33(19, 0, 0, 4);
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_last", last, 0);
    chk("mrst_i", out_i, 0);
    chk("mrst_j", out_j, 0);
    chk("mrst_auto", auto_cnt, 0);
    chk("mrst_static", static_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("mrst_no_done", done, 0);
    run33(1, 0, 0, 9);

    // 4-bit static counter across a 4x5 run, with start pulsed during RUN and DONE.
    outer_cfg = 8'd4; inner_cfg = 8'd5; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 20 && cyc < 100) begin
      out_ready = 1'b1;
      start4 = (cyc == 4);
      chk("w_valid", valid4, 1);
      chk("w_i", i4, k / 5);
      chk("w_j", j4, k % 5);
      chk("w_auto", auto4, k % 5 + 1);
      chk("w_static", static4, (k + 1) % 16);
      chk("w_last", last4, k == 19);
      k++;
      tick();
      cyc++;
    end
    start4 = 1'b0;
    chk("w_count", k, 20);
    chk("w_done", done4, 1);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("w_done_end", done4, 0);
    chk("w_idle_busy", busy4, 0);
    chk("w_idle_valid", valid4, 0);
    tick();
    chk("w_ignored_start", busy4, 0);
    chk("w_static_hold", static4, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
